spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master. It captures a transfer command from the Wishbone-side register file and generates SCLK edge timing from a programmable divider. It then shifts one character out on MOSI and in from MISO, drives the slave selects, and signals completion. It sits between the register file and the SPI pins, and owns the whole transfer from command to done pulse.

---
 rtl/spi_xfer_ctrl_if.sv | 34 +++
 rtl/spi_xfer_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of the register-file side command/status signals and the SPI pin signals of the
// SPI transfer sequencer.
//   master : drives the command (go, divider, char_len, cpol, cpha, auto_ss, ss_sel, tx_data)
//            and miso; observes rx_data, busy, done, sclk, mosi, ss_n.
//   slave  : the sequencer itself, the mirror image of master.
interface spi_xfer_ctrl_if #(
    parameter int unsigned SS_W = 8
);
    logic            go;
    logic [15:0]     divider;
    logic [4:0]      char_len;
    logic            cpol;
    logic            cpha;
    logic            auto_ss;
    logic [SS_W-1:0] ss_sel;
    logic [31:0]     tx_data;
    logic [31:0]     rx_data;
    logic            busy;
    logic            done;
    logic            sclk;
    logic            mosi;
    logic            miso;
    logic [SS_W-1:0] ss_n;

    modport master (
        output go, divider, char_len, cpol, cpha, auto_ss, ss_sel, tx_data, miso,
        input  rx_data, busy, done, sclk, mosi, ss_n
    );

    modport slave (
        input  go, divider, char_len, cpol, cpha, auto_ss, ss_sel, tx_data, miso,
        output rx_data, busy, done, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer. Captures a command on go, generates SCLK from a programmable
// half-period divider, shifts one character (1..32 bits, MSB first) out on mosi while shifting
// miso in, drives the slave selects and pulses done at the end.
// Ports:
//   wb_clk  : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : spi_xfer_ctrl_if.slave (command/status and SPI pins)
module spi_xfer_ctrl #(
    parameter int unsigned SS_W = 8
) (
    input logic            wb_clk,
    input logic            reset_n,
    spi_xfer_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

    state_e          state_q;
    logic [15:0]     div_q;
    logic [15:0]     cnt_q;
    logic [5:0]      len_q;
    logic            cpol_q;
    logic            cpha_q;
    logic [SS_W-1:0] ss_n_q;
    logic [31:0]     tx_shift_q;
    logic [31:0]     rx_shift_q;
    logic [31:0]     rx_data_q;
    logic [6:0]      edge_cnt_q;
    logic            sclk_q;
    logic            mosi_q;
    logic            busy_q;
    logic            done_q;

    logic [5:0]  len_in;
    logic [31:0] tx_aligned;
    logic        strobe;
    logic        leading;
    logic        last_edge;
    logic        sample;
    logic        shift_out;

    always_comb begin
        len_in     = (bus.char_len == 5'd0) ? 6'd32 : {1'b0, bus.char_len};
        // Left-align so the first bit to send always sits in bit 31.
        tx_aligned = bus.tx_data << (6'd32 - len_in);
        strobe     = (cnt_q == 16'd0);
        // edge_cnt_q counts strobes already issued, so an even count means the next one is odd.
        leading    = ~edge_cnt_q[0];
        last_edge  = (edge_cnt_q == ({len_q, 1'b0} - 7'd1));
        sample     = strobe && (leading ^ cpha_q);
        shift_out  = strobe && (cpha_q ? leading : (~leading && ~last_edge));
    end

    always_ff @(posedge wb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            ss_n_q     <= '1;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && state_q != StDone) begin
                cnt_q <= strobe ? div_q : cnt_q - 16'd1;
            end
            case (state_q)
                StIdle: begin
                    sclk_q <= bus.cpol;
                    mosi_q <= 1'b0;
                    if (bus.go) begin
                        div_q      <= bus.divider;
                        cnt_q      <= bus.divider;
                        len_q      <= len_in;
                        cpol_q     <= bus.cpol;
                        cpha_q     <= bus.cpha;
                        ss_n_q     <= ~bus.ss_sel;
                        rx_shift_q <= '0;
                        edge_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StSetup;
                        // cpha=0 presents the first bit before the first edge.
                        if (bus.cpha) begin
                            tx_shift_q <= tx_aligned;
                        end else begin
                            mosi_q     <= tx_aligned[31];
                            tx_shift_q <= tx_aligned << 1;
                        end
                    end
                end
                StSetup: begin
                    sclk_q <= cpol_q;
                    if (strobe) begin
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (sample) begin
                        rx_shift_q <= {rx_shift_q[30:0], bus.miso};
                    end
                    if (shift_out) begin
                        mosi_q     <= tx_shift_q[31];
                        tx_shift_q <= {tx_shift_q[30:0], 1'b0};
                    end
                    if (strobe) begin
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + 7'd1;
                        if (last_edge) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    sclk_q <= cpol_q;
                    if (strobe) begin
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_shift_q;
                        ss_n_q    <= '1;
                        mosi_q    <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    // Manual select mode follows ss_sel live, independent of the sequencer.
    assign bus.ss_n    = bus.auto_ss ? ss_n_q : ~bus.ss_sel;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;

    logic wb_clk  = 1'b0;
    logic reset_n = 1'b0;

    spi_xfer_ctrl_if #(.SS_W(8)) bus ();

    spi_xfer_ctrl #(.SS_W(8)) dut (
        .wb_clk  (wb_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 wb_clk = ~wb_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge wb_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // miso source: 0 loopback from mosi, 1 constant, 2 slave model
    logic [1:0] miso_mode  = 2'd0;
    logic       miso_const = 1'b0;
    logic       slv_miso;
    assign bus.miso = (miso_mode == 2'd0) ? bus.mosi :
                      (miso_mode == 2'd1) ? miso_const : slv_miso;

    logic tb_cpol = 1'b0;
    logic tb_cpha = 1'b0;

    // Slave model: shifts slv_pattern out on its shift edge, captures mosi on its sample edge.
    logic       slv_load    = 1'b0;
    logic       slv_en      = 1'b0;
    logic [7:0] slv_pattern = 8'h00;
    logic [7:0] slv_tx;
    logic [7:0] slv_rx;
    logic       slv_sclk_prev;
    always @(bus.sclk or posedge slv_load) begin
        if (slv_load) begin
            slv_rx        = 8'h00;
            slv_tx        = slv_pattern;
            slv_miso      = 1'b0;
            slv_sclk_prev = bus.sclk;
            if (!tb_cpha) begin
                slv_miso = slv_tx[7];
                slv_tx   = slv_tx << 1;
            end
        end else if (slv_en && bus.sclk !== slv_sclk_prev) begin
            slv_sclk_prev = bus.sclk;
            if ((bus.sclk != tb_cpol) ^ tb_cpha) begin
                slv_rx = {slv_rx[6:0], bus.mosi};
            end else begin
                slv_miso = slv_tx[7];
                slv_tx   = slv_tx << 1;
            end
        end
    end

    // Waveform monitor sampled on the falling wb_clk edge.
    logic        mon_clr = 1'b1;
    logic        sclk_prev;
    logic        seen_edge;
    int          phase_len, phase_min, phase_max, lead_cnt, ss_bad;
    logic [31:0] mosi_bits;
    always @(negedge wb_clk) begin
        if (mon_clr) begin
            phase_len = 0;
            phase_min = 1000;
            phase_max = 0;
            lead_cnt  = 0;
            ss_bad    = 0;
            mosi_bits = '0;
            seen_edge = 1'b0;
            sclk_prev = bus.sclk;
        end else begin
            phase_len++;
            if (bus.sclk !== sclk_prev) begin
                if (seen_edge) begin
                    if (phase_len < phase_min) phase_min = phase_len;
                    if (phase_len > phase_max) phase_max = phase_len;
                end
                seen_edge = 1'b1;
                phase_len = 0;
                if (bus.sclk != tb_cpol) lead_cnt++;
                if ((bus.sclk != tb_cpol) == !tb_cpha) mosi_bits = {mosi_bits[30:0], bus.mosi};
            end
            if (bus.busy !== ~bus.ss_n[0]) ss_bad++;
            sclk_prev = bus.sclk;
        end
    end

    int done_cnt = 0;
    always @(negedge wb_clk) if (bus.done === 1'b1) done_cnt++;

    task automatic prep(input logic cpol, input logic cpha);
        @(posedge wb_clk);
        #1;
        bus.cpol = cpol;
        bus.cpha = cpha;
        tb_cpol  = cpol;
        tb_cpha  = cpha;
        mon_clr  = 1'b1;
        repeat (2) @(posedge wb_clk);
        #1;
        mon_clr = 1'b0;
    endtask

    // Returns one cycle after go was raised; t0 is the cycle in which go was high.
    task automatic run_go(input logic [15:0] div, input logic [4:0] len, input logic [7:0] sel,
                          input logic [31:0] tx, output int t0);
        @(posedge wb_clk);
        #1;
        bus.divider  = div;
        bus.char_len = len;
        bus.ss_sel   = sel;
        bus.tx_data  = tx;
        bus.go       = 1'b1;
        t0           = cyc;
        @(posedge wb_clk);
        #1;
        bus.go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge wb_clk);
            if (bus.done === 1'b1) begin
                when = cyc;
                break;
            end
        end
        if (when < 0) check(tag, 32'd0, 32'd1);
    endtask

    int t0, when, dc;

    initial begin
        bus.go       = 1'b0;
        bus.divider  = 16'd0;
        bus.char_len = 5'd8;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        bus.auto_ss  = 1'b1;
        bus.ss_sel   = 8'h01;
        bus.tx_data  = 32'h0;

        #12;
        check("rst_sclk", {31'd0, bus.sclk}, 32'd0);
        check("rst_mosi", {31'd0, bus.mosi}, 32'd0);
        check("rst_ss_n", {24'd0, bus.ss_n}, 32'hFF);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rx", bus.rx_data, 32'd0);
        @(negedge wb_clk);
        reset_n = 1'b1;

        // Basic loopback, mode 0, fastest clock
        miso_mode = 2'd0;
        prep(1'b0, 1'b0);
        run_go(16'd0, 5'd8, 8'h01, 32'h000000A5, t0);
        wait_done("t1_timeout", 100, when);
        check("t1_latency", when - t0, 32'd19);
        check("t1_rx", bus.rx_data, 32'h000000A5);
        check("t1_sclk_idle", {31'd0, bus.sclk}, 32'd0);
        check("t1_busy_at_done", {31'd0, bus.busy}, 32'd0);
        @(negedge wb_clk);
        check("t1_done_pulse", {31'd0, bus.done}, 32'd0);
        check("t1_pulses", lead_cnt, 32'd8);
        check("t1_ss_vs_busy", ss_bad, 32'd0);

        // 32-bit, cpol=1 cpha=1, divider 3, miso held high
        miso_mode  = 2'd1;
        miso_const = 1'b1;
        prep(1'b1, 1'b1);
        run_go(16'd3, 5'd0, 8'h01, 32'h12345678, t0);
        wait_done("t2_timeout", 400, when);
        check("t2_latency", when - t0, 32'd265);
        check("t2_rx", bus.rx_data, 32'hFFFFFFFF);
        check("t2_mosi_seq", mosi_bits, 32'h12345678);
        check("t2_phase_min", phase_min, 32'd4);
        check("t2_phase_max", phase_max, 32'd4);
        check("t2_sclk_idle", {31'd0, bus.sclk}, 32'd1);

        // Slave model in both phase modes
        miso_mode = 2'd2;
        for (int m = 0; m < 2; m++) begin
            prep(1'b0, m[0]);
            slv_pattern = 8'h3C;
            slv_load    = 1'b1;
            #1;
            slv_load = 1'b0;
            slv_en   = 1'b1;
            run_go(16'd1, 5'd8, 8'h01, 32'h00000096, t0);
            wait_done("t3_timeout", 100, when);
            check(m == 0 ? "t3_cpha0_rx" : "t3_cpha1_rx", bus.rx_data, 32'h0000003C);
            check(m == 0 ? "t3_cpha0_slave_rx" : "t3_cpha1_slave_rx", {24'd0, slv_rx}, 32'h96);
            check(m == 0 ? "t3_cpha0_latency" : "t3_cpha1_latency", when - t0, 32'd37);
            slv_en = 1'b0;
        end

        // Second go during a transfer is ignored
        miso_mode = 2'd0;
        prep(1'b0, 1'b0);
        dc = done_cnt;
        run_go(16'd1, 5'd8, 8'h01, 32'h0000005A, t0);
        repeat (4) @(posedge wb_clk);
        #1;
        bus.divider = 16'd0;
        bus.tx_data = 32'h000000FF;
        bus.go      = 1'b1;
        @(posedge wb_clk);
        #1;
        bus.go = 1'b0;
        wait_done("t4_timeout", 100, when);
        check("t4_latency", when - t0, 32'd37);
        check("t4_rx", bus.rx_data, 32'h0000005A);
        repeat (50) @(negedge wb_clk);
        check("t4_done_count", done_cnt - dc, 32'd1);

        // Asynchronous reset mid-transfer
        prep(1'b0, 1'b0);
        run_go(16'd1, 5'd8, 8'h01, 32'h0000000F, t0);
        repeat (4) @(posedge wb_clk);
        #1;
        check("t5_sclk_high", {31'd0, bus.sclk}, 32'd1);
        dc      = done_cnt;
        reset_n = 1'b0;
        #1;
        check("t5_rst_sclk", {31'd0, bus.sclk}, 32'd0);
        check("t5_rst_ss_n", {24'd0, bus.ss_n}, 32'hFF);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge wb_clk);
        #1;
        reset_n = 1'b1;
        repeat (60) @(negedge wb_clk);
        check("t5_no_done", done_cnt - dc, 32'd0);
        run_go(16'd1, 5'd8, 8'h01, 32'h000000C3, t0);
        wait_done("t5_timeout", 100, when);
        check("t5_latency", when - t0, 32'd37);
        check("t5_rx", bus.rx_data, 32'h000000C3);

        // Manual slave select
        @(posedge wb_clk);
        #1;
        bus.auto_ss = 1'b0;
        bus.ss_sel  = 8'h81;
        #1;
        check("t6_manual_idle", {24'd0, bus.ss_n}, 32'h7E);
        run_go(16'd0, 5'd8, 8'h81, 32'h00000011, t0);
        repeat (5) @(posedge wb_clk);
        #1;
        check("t6_manual_xfer", {24'd0, bus.ss_n}, 32'h7E);
        wait_done("t6_timeout", 100, when);
        check("t6_manual_done", {24'd0, bus.ss_n}, 32'h7E);

        // Automatic slave select
        @(posedge wb_clk);
        #1;
        bus.auto_ss = 1'b1;
        bus.ss_sel  = 8'h02;
        #1;
        check("t6_auto_idle", {24'd0, bus.ss_n}, 32'hFF);
        run_go(16'd0, 5'd8, 8'h02, 32'h00000022, t0);
        check("t6_auto_setup", {24'd0, bus.ss_n}, 32'hFD);
        repeat (8) @(posedge wb_clk);
        #1;
        check("t6_auto_xfer", {24'd0, bus.ss_n}, 32'hFD);
        wait_done("t6_auto_timeout", 100, when);
        check("t6_auto_done", {24'd0, bus.ss_n}, 32'hFF);
        check("t6_auto_rx", bus.rx_data, 32'h00000022);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
